noc_rsc_ni: RTL and testbench

Resource-side network interface between one processing resource and its local port of the 2D mesh XY NoC. The TX path packs core requests into NoC packets and writes them into the switch's local input FIFO, retrying when the switch reports an overflow. The RX path buffers packets delivered by the switch's local output in a FIFO and hands them to the core over a valid/ready interface. One instance is placed per mesh node.

---
 rtl/noc_rsc_ni.sv | 186 ++++++++++++++++++
 tb/tb_noc_rsc_ni.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_rsc_ni.sv
// Resource-side NI: packs core requests into mesh packets with overflow retry, and buffers delivered packets in a FWFT FIFO.
// Latency: TX write strobe 2 cycles after accept, ready again after 4 at best; RX head visible the cycle after the write.
// Backpressure: TX waits while noc_full_i is high and retries on overflow; RX writes arriving while full are dropped and counted.
module noc_rsc_ni #(
  parameter int ROW_N        = 3,
  parameter int COL_M        = 3,
  parameter int ROW_CORD     = 0,
  parameter int COL_CORD     = 0,
  parameter int PCKT_DATA_W  = 8,
  parameter int FIFO_DEPTH_W = 2,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 16,
  localparam int RW = $clog2(ROW_N),
  localparam int CW = $clog2(COL_M),
  localparam int PW = PCKT_DATA_W + RW + CW
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [RW-1:0]          tx_row_i,
  input  logic [CW-1:0]          tx_col_i,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  output logic                   tx_err_o,
  output logic [PW-1:0]          noc_pckt_o,
  output logic                   noc_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  input  logic [PW-1:0]          noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   rsc_full_o,
  output logic                   rsc_ovrflw_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [RW-1:0]          rx_row_o,
  output logic [CW-1:0]          rx_col_o,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic                   rx_misroute_o,
  output logic [CNT_W-1:0]       tx_cnt_o,
  output logic [CNT_W-1:0]       drop_cnt_o
);

  localparam int DEPTH = 1 << FIFO_DEPTH_W;
  localparam int RTW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [PCKT_DATA_W-1:0] dat;
  } pckt_t;

  typedef enum logic [1:0] {IDLE, SEND, WR, CHECK} tx_state_t;

  tx_state_t        state_q, state_d;
  logic [RTW-1:0]   retry_q;
  logic             latch, retry_inc, tx_ok, tx_drop;

  logic [PW-1:0]           mem [DEPTH];
  logic [FIFO_DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_W:0]   occ, occ_nxt;
  logic                    push, pop, rx_drop;
  pckt_t                   head;

  logic [1:0]       drop_inc;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  // TX state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // TX next-state logic and per-state control strobes
  always_comb begin
    state_d    = state_q;
    tx_ready_o = 1'b0;
    latch      = 1'b0;
    retry_inc  = 1'b0;
    tx_ok      = 1'b0;
    tx_drop    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_ready_o = 1'b1;
        if (tx_valid_i) begin
          latch   = 1'b1;
          state_d = SEND;
        end
      end
      SEND:  if (!noc_full_i) state_d = WR;
      WR:    state_d = CHECK;
      CHECK: begin
        // the switch reports overflow one cycle after our strobe
        if (!noc_ovrflw_i) begin
          tx_ok   = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RTW'(MAX_RETRY)) begin
          retry_inc = 1'b1;
          state_d   = SEND;
        end else begin
          tx_drop = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // TX datapath: packet latch, write strobe flop, retry count, error pulse, sent counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      noc_pckt_o <= '0;
      noc_wren_o <= 1'b0;
      retry_q    <= '0;
      tx_err_o   <= 1'b0;
      tx_cnt_o   <= '0;
    end else begin
      noc_wren_o <= (state_d == WR);
      tx_err_o   <= tx_drop;
      if (latch) begin
        noc_pckt_o <= {tx_col_i, tx_row_i, tx_data_i};
        retry_q    <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + 1'b1;
      end
      if (tx_ok && (tx_cnt_o != CNT_MAX)) tx_cnt_o <= tx_cnt_o + 1'b1;
    end
  end

  // RX FIFO handshake decode; a write while full is lost even if a pop frees a slot this cycle
  always_comb begin
    push    = noc_wren_i & ~rsc_full_o;
    pop     = rx_valid_o & rx_ready_i;
    rx_drop = noc_wren_i & rsc_full_o;
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
  end

  // RX FIFO pointers, occupancy and registered status flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      rsc_full_o   <= 1'b0;
      rsc_ovrflw_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ          <= occ_nxt;
      rsc_full_o   <= (occ_nxt == (FIFO_DEPTH_W+1)'(DEPTH));
      rsc_ovrflw_o <= rx_drop;
    end
  end

  // RX storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= noc_pckt_i;
  end

  assign head          = mem[rd_ptr];
  assign rx_valid_o    = (occ != '0);
  assign rx_row_o      = head.row;
  assign rx_col_o      = head.col;
  assign rx_data_o     = head.dat;
  assign rx_misroute_o = (head.row != RW'(ROW_CORD)) || (head.col != CW'(COL_CORD));

  // saturating drop total; TX and RX drops in one cycle count as two
  always_comb begin
    drop_inc = 2'(tx_drop) + 2'(rx_drop);
    drop_sum = {1'b0, drop_cnt_o} + (CNT_W+1)'(drop_inc);
    drop_nxt = (drop_sum > {1'b0, CNT_MAX}) ? CNT_MAX : drop_sum[CNT_W-1:0];
  end

  // drop counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) drop_cnt_o <= '0;
    else       drop_cnt_o <= drop_nxt;
  end

endmodule

// File: tb/tb_noc_rsc_ni.sv
// Scoreboard bench for noc_rsc_ni: TX strobes and RX heads checked against queues fed by a packet-level model.
// Small counters (CNT_W=4) so saturation is reached; node at (1,1) so misrouted packets appear.
// Background processes emulate the switch (full/overflow) and a random RX source/sink.
module tb_noc_rsc_ni;
  localparam int ROW_N = 3, COL_M = 3, ROW_CORD = 1, COL_CORD = 1;
  localparam int DW = 8, FDW = 2, MAX_RETRY = 3, CNT_W = 4;
  localparam int RW = $clog2(ROW_N), CW = $clog2(COL_M), PW = DW + RW + CW;
  localparam int D = 1 << FDW, CMAX = (1 << CNT_W) - 1;

  logic clk, rst_i;
  logic tx_valid_i, tx_ready_o, tx_err_o;
  logic [RW-1:0] tx_row_i, rx_row_o;
  logic [CW-1:0] tx_col_i, rx_col_o;
  logic [DW-1:0] tx_data_i, rx_data_o;
  logic [PW-1:0] noc_pckt_o, noc_pckt_i;
  logic noc_wren_o, noc_full_i, noc_ovrflw_i, noc_wren_i;
  logic rsc_full_o, rsc_ovrflw_o, rx_valid_o, rx_ready_i, rx_misroute_o;
  logic [CNT_W-1:0] tx_cnt_o, drop_cnt_o;

  noc_rsc_ni #(.ROW_N(ROW_N), .COL_M(COL_M), .ROW_CORD(ROW_CORD), .COL_CORD(COL_CORD),
               .PCKT_DATA_W(DW), .FIFO_DEPTH_W(FDW), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .tx_row_i(tx_row_i), .tx_col_i(tx_col_i), .tx_data_i(tx_data_i), .tx_err_o(tx_err_o),
    .noc_pckt_o(noc_pckt_o), .noc_wren_o(noc_wren_o), .noc_full_i(noc_full_i),
    .noc_ovrflw_i(noc_ovrflw_i), .noc_pckt_i(noc_pckt_i), .noc_wren_i(noc_wren_i),
    .rsc_full_o(rsc_full_o), .rsc_ovrflw_o(rsc_ovrflw_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .rx_row_o(rx_row_o), .rx_col_o(rx_col_o), .rx_data_o(rx_data_o),
    .rx_misroute_o(rx_misroute_o), .tx_cnt_o(tx_cnt_o), .drop_cnt_o(drop_cnt_o));

  int n_cmp = 0, n_err = 0;
  logic [PW-1:0] wr_q[$];
  logic [PW-1:0] rx_exp[$];
  int  ovf_left = 0, rx_drops = 0, err_pulses = 0;
  int  exp_tx = 0, exp_txdrop = 0, exp_err = 0;
  int  full_mode = 1, rx_mode = 0;
  bit  exp_ovf = 0, prev_full = 0, mon_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int r, input int c, input int d);
    logic [RW-1:0] rr;
    logic [CW-1:0] cc;
    logic [DW-1:0] dd;
    rr = RW'(r);
    cc = CW'(c);
    dd = DW'(d);
    return {cc, rr, dd};
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  // switch emulation: overflow in the cycle after a strobe while budget remains; random fullness
  initial begin
    bit w;
    noc_ovrflw_i = 1'b0;
    forever begin
      @(negedge clk);
      w = noc_wren_o;
      @(posedge clk);
      #2;
      noc_ovrflw_i = w && (ovf_left > 0);
      if (noc_ovrflw_i) ovf_left--;
      if (full_mode == 0) noc_full_i = ($urandom_range(0, 99) < 30);
    end
  end

  // random RX source and sink
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rx_mode == 1) begin
        noc_wren_i = ($urandom_range(0, 1) == 1);
        noc_pckt_i = mk($urandom_range(0, ROW_N-1), $urandom_range(0, COL_M-1), $urandom_range(0, 255));
        rx_ready_i = ($urandom_range(0, 9) < 4);
      end
    end
  end

  // monitor: compare outputs with model state, then advance the RX model by this cycle's inputs
  always @(negedge clk) begin
    int occ0;
    logic [PW-1:0] h;
    if (mon_en) begin
      if (noc_wren_o) begin
        check("tx_wr_while_full", prev_full, 0);
        check("tx_wr_pending", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          h = wr_q.pop_front();
          check("tx_pckt", noc_pckt_o, h);
        end
      end
      if (tx_err_o) err_pulses++;
      occ0 = rx_exp.size();
      check("rx_valid", rx_valid_o, occ0 > 0);
      check("rsc_full", rsc_full_o, occ0 == D);
      check("rsc_ovrflw", rsc_ovrflw_o, exp_ovf);
      if (rx_ready_i && occ0 > 0) begin
        h = rx_exp.pop_front();
        check("rx_head", {rx_col_o, rx_row_o, rx_data_o}, h);
        check("rx_misroute", rx_misroute_o,
              (h[DW+RW-1:DW] != RW'(ROW_CORD)) || (h[PW-1 -: CW] != CW'(COL_CORD)));
      end
      if (rst_i) begin
        rx_exp.delete();
        wr_q.delete();
        exp_ovf = 0;
        rx_drops = 0;
      end else begin
        exp_ovf = noc_wren_i && (occ0 == D);
        if (noc_wren_i && occ0 < D) rx_exp.push_back(noc_pckt_i);
        if (exp_ovf) rx_drops++;
      end
    end
    prev_full = noc_full_i;
  end

  // one TX request; k = number of overflows the switch reports, stall = forced full cycles after accept
  task automatic tx_send(input int r, input int c, input int d, input int k, input int stall,
                         input bit manual, input bit chk_drop,
                         output int wr_n, output int lat, output logic [PW-1:0] pk);
    logic [PW-1:0] p;
    int nwr;
    bit acc;
    p = mk(r, c, d);
    nwr = (k > MAX_RETRY) ? MAX_RETRY + 1 : k + 1;
    repeat (nwr) wr_q.push_back(p);
    if (k > MAX_RETRY) begin exp_txdrop++; exp_err++; end
    else exp_tx++;
    ovf_left = (k > MAX_RETRY) ? MAX_RETRY + 1 : k;
    full_mode = manual ? 1 : 0;
    if (manual) noc_full_i = 1'b0;
    tx_row_i = RW'(r); tx_col_i = CW'(c); tx_data_i = DW'(d);
    tx_valid_i = 1'b1;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_ready_o) begin acc = 1; break; end
      @(posedge clk); #1;
    end
    check("tx_accept", acc, 1);
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    tx_row_i = RW'($urandom_range(0, ROW_N-1));
    tx_col_i = CW'($urandom_range(0, COL_M-1));
    tx_data_i = DW'($urandom_range(0, 255));
    if (manual) noc_full_i = (stall > 0);
    wr_n = 0; lat = 0; pk = '0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (noc_wren_o && wr_n == 0) begin wr_n = n; pk = noc_pckt_o; end
      if (tx_ready_o) begin lat = n; break; end
      @(posedge clk); #1;
      if (manual) noc_full_i = (n < stall);
    end
    #1;
    check("tx_done", lat != 0, 1);
    check("tx_cnt", tx_cnt_o, sat(exp_tx));
    check("tx_err_pulses", err_pulses, exp_err);
    check("tx_wr_all_seen", wr_q.size(), 0);
    if (chk_drop) check("drop_cnt", drop_cnt_o, sat(exp_txdrop + rx_drops));
    @(posedge clk); #1;
  endtask

  task automatic drain(output int cnt);
    rx_mode = 0;
    noc_wren_i = 1'b0;
    rx_ready_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!rx_valid_o) break;
      cnt++;
      @(posedge clk); #1;
    end
    check("drain_empty", rx_valid_o, 0);
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
  endtask

  initial begin
    int wr_n, lat, cnt, e0;
    logic [PW-1:0] pk;
    rst_i = 1'b1; tx_valid_i = 1'b0; tx_row_i = '0; tx_col_i = '0; tx_data_i = '0;
    noc_full_i = 1'b0; noc_pckt_i = '0; noc_wren_i = 1'b0; rx_ready_i = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_wren", noc_wren_o, 0);
    check("rst_pckt", noc_pckt_o, 0);
    check("rst_err", tx_err_o, 0);
    check("rst_tx_cnt", tx_cnt_o, 0);
    check("rst_drop_cnt", drop_cnt_o, 0);
    @(posedge clk); #1;

    // basic send
    tx_send(1, 2, 'hA5, 0, 0, 1, 1, wr_n, lat, pk);
    check("basic_pckt", pk, 'h9A5);
    check("basic_wr_cycle", wr_n, 2);
    check("basic_ready_cycle", lat, 4);
    // backpressure for 10 cycles
    tx_send(2, 0, 'h3C, 0, 10, 1, 1, wr_n, lat, pk);
    check("stall_pckt", pk, 'h23C);
    check("stall_wr_cycle", wr_n, 12);
    check("stall_ready_cycle", lat, 14);
    // retry exhaustion
    tx_send(0, 1, 'h11, 4, 0, 1, 1, wr_n, lat, pk);
    check("retry_ready_cycle", lat, 13);
    // a success after two retries
    tx_send(2, 2, 'h7E, 2, 0, 1, 1, wr_n, lat, pk);
    check("retry2_ready_cycle", lat, 10);
    // random TX with random switch fullness
    for (int i = 0; i < 20; i++)
      tx_send($urandom_range(0, ROW_N-1), $urandom_range(0, COL_M-1), $urandom_range(0, 255),
              $urandom_range(0, 5), 0, 0, 1, wr_n, lat, pk);

    // RX fill: five writes with no pops
    full_mode = 1; noc_full_i = 1'b0;
    rx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      noc_wren_i = 1'b1;
      noc_pckt_i = mk(i % ROW_N, (i + 1) % COL_M, 'h40 + i);
      @(posedge clk); #1;
    end
    noc_wren_i = 1'b0;
    @(negedge clk); #1;
    check("fill_ovrflw", rsc_ovrflw_o, 1);
    check("fill_full", rsc_full_o, 1);
    check("fill_drop_cnt", drop_cnt_o, sat(exp_txdrop + rx_drops));
    @(posedge clk); #1;
    drain(cnt);
    check("fill_drain_count", cnt, 4);

    // misroute at head, then push+pop at occupancy 2
    noc_wren_i = 1'b1; noc_pckt_i = mk(0, 2, 'h3C);
    @(posedge clk); #1;
    noc_pckt_i = mk(1, 1, 'h5A);
    @(negedge clk);
    check("misroute_head", rx_misroute_o, 1);
    @(posedge clk); #1;
    noc_pckt_i = mk(2, 0, 'h77); rx_ready_i = 1'b1;
    @(posedge clk); #1;
    noc_wren_i = 1'b0; rx_ready_i = 1'b0;
    @(negedge clk);
    check("pushpop_head_ok_route", rx_misroute_o, 0);
    @(posedge clk); #1;
    drain(cnt);
    check("pushpop_occupancy", cnt, 2);

    // random RX traffic
    rx_mode = 1;
    repeat (400) @(posedge clk);
    #1;
    drain(cnt);
    #1;
    check("rx_rand_drop_cnt", drop_cnt_o, sat(exp_txdrop + rx_drops));

    // concurrent TX and RX
    rx_mode = 1;
    for (int i = 0; i < 10; i++)
      tx_send($urandom_range(0, ROW_N-1), $urandom_range(0, COL_M-1), $urandom_range(0, 255),
              $urandom_range(0, 5), 0, 0, 0, wr_n, lat, pk);
    drain(cnt);
    #1;
    check("conc_drop_cnt", drop_cnt_o, sat(exp_txdrop + rx_drops));

    // reset while TX is stalled in SEND with RX data queued
    full_mode = 1; noc_full_i = 1'b1;
    noc_wren_i = 1'b1; noc_pckt_i = mk(2, 1, 'hC3);
    @(posedge clk); #1;
    noc_pckt_i = mk(0, 0, 'h3D);
    @(posedge clk); #1;
    noc_wren_i = 1'b0;
    ovf_left = 0;
    tx_row_i = 1; tx_col_i = 1; tx_data_i = 'hEE; tx_valid_i = 1'b1;
    @(posedge clk); #1;
    tx_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    e0 = err_pulses;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; noc_full_i = 1'b0;
    exp_tx = 0; exp_txdrop = 0;
    @(negedge clk);
    check("mrst_tx_ready", tx_ready_o, 1);
    check("mrst_wren", noc_wren_o, 0);
    check("mrst_pckt", noc_pckt_o, 0);
    check("mrst_rx_valid", rx_valid_o, 0);
    check("mrst_full", rsc_full_o, 0);
    check("mrst_tx_cnt", tx_cnt_o, 0);
    check("mrst_drop_cnt", drop_cnt_o, 0);
    repeat (5) @(negedge clk);
    #1;
    check("mrst_no_err", err_pulses, e0);
    check("mrst_no_wr", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
